// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, in-order
// response FIFO tagged with PC, redirect flush with in-flight discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] bus_cmd_addr,
  output logic        bus_cmd_en,
  output logic        bus_cmd_we,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   CAP_C   = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   mem_data [FIFO_DEPTH];
  logic [31:0]   mem_pc   [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] out_left;
  logic [CW:0]   credit;
  logic [31:0]   new_pc;
  logic          push;
  logic          pop;
  logic          drop;
  logic          unused_ok;

  assign unused_ok = ^redirect_pc[1:0];
  assign new_pc    = {redirect_pc[31:2], 2'b00};

  assign credit = {1'b0, count} + {1'b0, outstanding};

  assign bus_cmd_en   = rstn && !redirect_valid && (credit < CAP_C);
  assign bus_cmd_addr = fetch_pc;
  assign bus_cmd_we   = 1'b0;

  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? mem_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr]   : '0;

  assign drop = bus_rsp_ready && (discard != '0);
  assign push = bus_rsp_ready && (discard == '0) && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  // In-flight count once this cycle's response (if any) is retired
  assign out_left = outstanding - CW'(bus_rsp_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= new_pc;
      rsp_pc      <= new_pc;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= out_left;
      discard     <= out_left;
    end else begin
      if (bus_cmd_en)
        fetch_pc <= fetch_pc + 32'd4;
      outstanding <= out_left + CW'(bus_cmd_en);
      if (drop)
        discard <= discard - CW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus_rsp_rdata;
      mem_pc[wr_ptr]   <= rsp_pc;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rstn)
    !(push && !pop && (count == DEPTH_C))
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized bus latency, stalls,
// redirects and resets checked against a program-order stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] bus_cmd_addr;
  logic        bus_cmd_en;
  logic        bus_cmd_we;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus_cmd_addr  (bus_cmd_addr),
    .bus_cmd_en    (bus_cmd_en),
    .bus_cmd_we    (bus_cmd_we),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_ready (bus_rsp_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_hs  = 0;
  int          cyc   = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          last_due = 0;
  int          since = 0;
  req_t        bq[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC0DE_0F1D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected program order: sequential words from the restart point
  task automatic reseed(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 256; i++)
      exp_q.push_back({pc[31:2], 2'b00} + 32'(4 * i));
    since = 0;
  endtask

  // Bus model: in-order, per-request latency, at most one response/cycle
  always @(negedge clk) begin
    int d;
    if (rstn === 1'b1 && bus_cmd_en === 1'b1) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      bq.push_back('{bus_cmd_addr, d});
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rstn !== 1'b1) begin
      bq.delete();
      last_due      = 0;
      bus_rsp_ready = 1'b0;
    end else if (bq.size() > 0 && bq[0].due <= cyc) begin
      bus_rsp_ready = 1'b1;
      bus_rsp_rdata = word_of(bq[0].addr);
      void'(bq.pop_front());
    end else begin
      bus_rsp_ready = 1'b0;
      bus_rsp_rdata = $urandom;
    end
  end

  // Monitor: every accepted instruction must be next in program order
  always @(negedge clk) begin
    logic [31:0] e;
    if (rstn === 1'b1 && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream_underrun: got pc %h expected none", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", instr_pc, e);
        chk("instr_data", instr_data, word_of(e));
        n_hs++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    rstn = 1'b0;
    redirect_valid = 1'b0;
    reseed(32'h0);
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    reseed(pc);
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_cmd(input string name, input logic [31:0] exp);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus_cmd_en) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no command expected addr %h", name, exp);
    end else
      chk(name, bus_cmd_addr, exp);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no instr_valid expected pc %h", name, exp);
    end else
      chk(name, instr_pc, exp);
  endtask

  initial begin
    int first_en;
    int first_v;
    int n_en;
    int r;
    logic [31:0] first_addr;
    logic [31:0] addrs[2];

    rstn           = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    bus_rsp_ready  = 1'b0;
    bus_rsp_rdata  = 32'h0;
    reseed(32'h0);

    // Reset state
    @(negedge clk);
    chk("rst_cmd_en", 32'(bus_cmd_en), 32'd0);
    chk("rst_cmd_addr", bus_cmd_addr, 32'h0);
    chk("rst_cmd_we", 32'(bus_cmd_we), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", instr_data, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);

    // First fetch and fetch-to-valid latency with a 1-cycle bus
    step();
    rstn = 1'b1;
    first_en = -1;
    first_v  = -1;
    first_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_cmd_en && first_en < 0) begin
        first_en   = i;
        first_addr = bus_cmd_addr;
      end
      if (instr_valid && first_v < 0) first_v = i;
    end
    chk("first_cmd_addr", first_addr, 32'h0);
    chk("fetch_to_valid", 32'(first_v - first_en), 32'd2);

    // Consumer stalled: credit limit caps fetches at two
    instr_ready = 1'b0;
    do_reset();
    n_en = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_cmd_en) begin
        if (n_en < 2) addrs[n_en] = bus_cmd_addr;
        n_en++;
      end
    end
    chk("stall_cmds", 32'(n_en), 32'd2);
    chk("stall_addr0", addrs[0], 32'h0);
    chk("stall_addr1", addrs[1], 32'h4);
    chk("stall_en_low", 32'(bus_cmd_en), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    step();
    instr_ready = 1'b1;
    wait_cmd("resume_addr", 32'h8);

    // Redirect with two fetches in flight on a 3-cycle bus
    lat_min = 3;
    lat_max = 3;
    do_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    reseed(32'h100);
    @(negedge clk);
    chk("redir_en_low", 32'(bus_cmd_en), 32'd0);
    step();
    redirect_valid = 1'b0;
    wait_cmd("redir_cmd", 32'h100);
    wait_valid("redir_pc", 32'h100);

    // Misaligned redirect target is word-aligned
    redirect(32'h203);
    wait_cmd("align_cmd", 32'h200);
    wait_valid("align_pc", 32'h200);

    // Reset mid-stream
    instr_ready = 1'b0;
    repeat (6) step();
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    step();
    rstn = 1'b0;
    reseed(32'h0);
    @(negedge clk);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_en", 32'(bus_cmd_en), 32'd0);
    step();
    step();
    rstn = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("restart_en", 32'(bus_cmd_en), 32'd1);
    chk("restart_addr", bus_cmd_addr, 32'h0);

    // Randomized traffic: stalls, latency 1..4, redirects, resets
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      step();
      since++;
      instr_ready = ($urandom_range(9, 0) < 7);
      r = int'($urandom_range(99, 0));
      if (rstn == 1'b0) begin
        rstn = 1'b1;
      end else if (r == 99) begin
        rstn = 1'b0;
        redirect_valid = 1'b0;
        reseed(32'h0);
      end else if (r < 4 || since >= 200) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
        reseed(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
    end
    rstn = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (20) step();
    chk("progress", 32'(n_hs > 300), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
